// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_pkg                                                      |
// | Brief  : Shared widths, FIFO entry type and rd decode for writeback  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int RSEL_W = 3;
  localparam int NREGS  = 8;

  typedef struct packed {
    logic              valid;
    logic [RSEL_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } fifo_ent_t;

  // r0 is hard-wired, so it never shows up as a pending write.
  function automatic logic [NREGS-1:0] rd_onehot(input logic [RSEL_W-1:0] rd);
    logic [NREGS-1:0] v;
    v = '0;
    if (rd != '0) v[rd] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_fifo2                                                    |
// | Brief  : 2-entry ALU result queue with invalidate-by-rd and compaction|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module wb_fifo2
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [RSEL_W-1:0] push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              inv_i,
  input  logic [RSEL_W-1:0] inv_rd_i,
  output fifo_ent_t         head_o,
  output logic              ready_o,
  output logic [NREGS-1:0]  busy_o
);

  localparam logic [1:0] c_depth = 2'(DEPTH);

  fifo_ent_t [1:0] ent_q, ent_d;
  logic [1:0]      cnt_d;
  logic            ready_q, ready_d;

  // Order of operations: invalidate, compact so entry 0 is the oldest
  // survivor, pop, then append the new result behind everything kept.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < 2; i++) begin
      if (inv_i && (ent_d[i].rd == inv_rd_i)) ent_d[i].valid = 1'b0;
    end
    if (!ent_d[0].valid) begin
      ent_d[0] = ent_d[1];
      ent_d[1] = '0;
    end
    if (pop_i) begin
      ent_d[0] = ent_d[1];
      ent_d[1] = '0;
    end
    if (push_i) begin
      if (!ent_d[0].valid) ent_d[0] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
      else                 ent_d[1] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
    end
    cnt_d   = 2'(ent_d[0].valid) + 2'(ent_d[1].valid);
    ready_d = (cnt_d < c_depth);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < 2; i++) begin
      if (ent_q[i].valid) busy_o = busy_o | rd_onehot(ent_q[i].rd);
    end
  end

  assign head_o  = ent_q[0];
  assign ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_arbiter                                                  |
// | Brief  : Register-file write arbiter, loads over queued ALU results  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [RSEL_W-1:0] alu_rd,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [RSEL_W-1:0] mem_rd,
  input  logic              mem_he,
  input  logic              mem_be,
  output logic [DATA_W-1:0] regw,
  output logic [RSEL_W-1:0] regws,
  output logic              we,
  output logic              he,
  output logic              be,
  output logic [NREGS-1:0]  busy
);

  fifo_ent_t          head;
  logic               fifo_ready;
  logic [NREGS-1:0]   fifo_busy;
  logic               push, pop;

  logic [DATA_W-1:0]  regw_q, regw_d;
  logic [RSEL_W-1:0]  regws_q, regws_d;
  logic               we_q, we_d;
  logic               he_q, he_d;
  logic               be_q, be_d;

  assign push = alu_valid && fifo_ready;
  assign pop  = !mem_valid && head.valid;

  wb_fifo2 #(
    .DEPTH       (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_rd_i   (alu_rd),
    .push_data_i (alu_data),
    .pop_i       (pop),
    .inv_i       (mem_valid),
    .inv_rd_i    (mem_rd),
    .head_o      (head),
    .ready_o     (fifo_ready),
    .busy_o      (fifo_busy)
  );

  // A consumed r0 entry still leaves the write port idle and all-zero.
  always_comb begin
    regw_d  = '0;
    regws_d = '0;
    we_d    = 1'b0;
    he_d    = 1'b0;
    be_d    = 1'b0;
    if (mem_valid) begin
      if (mem_rd != '0) begin
        we_d    = 1'b1;
        regws_d = mem_rd;
        regw_d  = mem_data;
        he_d    = mem_he && !mem_be;
        be_d    = mem_be && !mem_he;
      end
    end else if (head.valid && (head.rd != '0)) begin
      we_d    = 1'b1;
      regws_d = head.rd;
      regw_d  = head.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regw_q  <= '0;
      regws_q <= '0;
      we_q    <= 1'b0;
      he_q    <= 1'b0;
      be_q    <= 1'b0;
    end else begin
      regw_q  <= regw_d;
      regws_q <= regws_d;
      we_q    <= we_d;
      he_q    <= he_d;
      be_q    <= be_d;
    end
  end

  assign regw      = regw_q;
  assign regws     = regws_q;
  assign we        = we_q;
  assign he        = he_q;
  assign be        = be_q;
  assign alu_ready = fifo_ready;
  assign busy      = fifo_busy | (we_q ? rd_onehot(regws_q) : '0);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_wb_arbiter                                               |
// | Brief  : Directed + random bench against a queue-based writeback model|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [15:0] alu_data = '0;
  logic [2:0]  alu_rd = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic [2:0]  mem_rd = '0;
  logic        mem_he = 1'b0;
  logic        mem_be = 1'b0;
  logic [15:0] regw;
  logic [2:0]  regws;
  logic        we, he, be;
  logic [7:0]  busy;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_rd(alu_rd),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_rd(mem_rd),
    .mem_he(mem_he), .mem_be(mem_be),
    .regw(regw), .regws(regws), .we(we), .he(he), .be(be), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  logic        e_we, e_he, e_be, e_ready;
  logic [15:0] e_regw;
  logic [2:0]  e_regws;
  bit          last_acc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_busy();
    logic [7:0] b;
    b = '0;
    foreach (q[i]) if (q[i].rd != 0) b[q[i].rd] = 1'b1;
    if (e_we) b[e_regws] = 1'b1;
    return b;
  endfunction

  task automatic check_all();
    check("we",        32'(we),        32'(e_we));
    check("regw",      32'(regw),      32'(e_regw));
    check("regws",     32'(regws),     32'(e_regws));
    check("he",        32'(he),        32'(e_he));
    check("be",        32'(be),        32'(e_be));
    check("busy",      32'(busy),      32'(exp_busy()));
    check("alu_ready", 32'(alu_ready), 32'(e_ready));
  endtask

  task automatic model_clear();
    q.delete();
    e_we = 0; e_he = 0; e_be = 0; e_regw = '0; e_regws = '0; e_ready = 0;
  endtask

  // One clock of stimulus; model advanced at the edge, DUT checked at negedge.
  task automatic step(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                      input logic mv, input logic [2:0] mrd, input logic [15:0] md,
                      input logic mh, input logic mb);
    ent_t keep[$];
    ent_t h;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; mem_he = mh; mem_be = mb;
    @(posedge clk);
    last_acc = av && e_ready;
    e_we = 0; e_he = 0; e_be = 0; e_regw = '0; e_regws = '0;
    if (mv) begin
      foreach (q[i]) if (q[i].rd != mrd) keep.push_back(q[i]);
      q = keep;
      if (mrd != 0) begin
        e_we = 1; e_regws = mrd; e_regw = md;
        e_he = mh && !mb;
        e_be = mb && !mh;
      end
    end else if (q.size() > 0) begin
      h = q.pop_front();
      if (h.rd != 0) begin
        e_we = 1; e_regws = h.rd; e_regw = h.data;
      end
    end
    if (last_acc) q.push_back({ard, ad});
    e_ready = (q.size() < 2);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit          pend;
  logic [2:0]  prd;
  logic [15:0] pdata;

  initial begin
    model_clear();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // single ALU result, two cycles to the write port
    step(1, 3'd1, 16'h01ff, 0, 0, 0, 0, 0);
    idle(3);

    // loads held while three ALU results queue up behind them
    step(1, 3'd4, 16'hA001, 1, 3'd2, 16'h2222, 0, 0);
    step(1, 3'd5, 16'hA002, 1, 3'd2, 16'h2223, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 3'd6, 16'hA003, (k < 2), 3'd2, 16'h2224, 0, 0);
      if (last_acc) break;
    end
    check("alu3_accepted", 32'(last_acc), 32'd1);
    idle(4);

    // load kills an older queued result to the same register
    step(1, 3'd3, 16'h1111, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd3, 16'h007f, 0, 1);
    idle(3);

    // both byte strobes collapse to a full-word write
    step(0, 0, 0, 1, 3'd7, 16'hBEEF, 1, 1);
    step(0, 0, 0, 1, 3'd7, 16'hBE00, 1, 0);
    idle(1);

    // everything aimed at r0 is swallowed
    step(1, 3'd0, 16'h5555, 1, 3'd0, 16'h6666, 0, 0);
    idle(3);

    // same-cycle ALU and load to one register: ALU result survives
    step(1, 3'd4, 16'h4444, 1, 3'd4, 16'h0404, 0, 0);
    idle(3);

    // reset mid-stream with the queue full
    step(1, 3'd1, 16'hC001, 1, 3'd7, 16'h7777, 0, 0);
    step(1, 3'd2, 16'hC002, 1, 3'd7, 16'h7778, 0, 0);
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    check_all();
    alu_valid = 0; mem_valid = 0;
    reset = 1'b1;
    idle(4);

    // random traffic, ALU offers held until accepted
    pend = 0; prd = '0; pdata = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && ($urandom_range(0, 9) < 6)) begin
        pend  = 1;
        prd   = 3'($urandom_range(0, 7));
        pdata = 16'($urandom);
      end
      step(pend, prd, pdata,
           ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (last_acc) pend = 0;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
